// File: rtl/sha_sigma_pipe.sv
// SHA-2 sigma/Ch/Maj engine behind a STAGES-deep valid/ready pipeline, 32- or 64-bit words.
// Define SHA_SIGMA_CHMAJ_EN to implement modes 4 (Ch) and 5 (Maj); otherwise they report out_err.
module sha_sigma_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_mode,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_z,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  generate
    if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
      $error("sha_sigma_pipe: WIDTH must be 32 or 64");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("sha_sigma_pipe: STAGES must be 1..4");
    end
  endgenerate

  localparam bit W64 = (WIDTH == 64);
  localparam int S0A = W64 ? 1  : 7;
  localparam int S0B = W64 ? 8  : 18;
  localparam int S0C = W64 ? 7  : 3;
  localparam int S1A = W64 ? 19 : 17;
  localparam int S1B = W64 ? 61 : 19;
  localparam int S1C = W64 ? 6  : 10;
  localparam int B0A = W64 ? 28 : 2;
  localparam int B0B = W64 ? 34 : 13;
  localparam int B0C = W64 ? 39 : 22;
  localparam int B1A = W64 ? 14 : 6;
  localparam int B1B = W64 ? 18 : 11;
  localparam int B1C = W64 ? 41 : 25;

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v, input int n);
    return (v >> n) | (v << (WIDTH - n));
  endfunction

  logic [WIDTH-1:0] f_data;
  logic             f_err;

  always_comb begin
    f_data = '0;
    f_err  = 1'b0;
    case (in_mode)
      3'd0: f_data = rotr(in_x, S0A) ^ rotr(in_x, S0B) ^ (in_x >> S0C);
      3'd1: f_data = rotr(in_x, S1A) ^ rotr(in_x, S1B) ^ (in_x >> S1C);
      3'd2: f_data = rotr(in_x, B0A) ^ rotr(in_x, B0B) ^ rotr(in_x, B0C);
      3'd3: f_data = rotr(in_x, B1A) ^ rotr(in_x, B1B) ^ rotr(in_x, B1C);
`ifdef SHA_SIGMA_CHMAJ_EN
      3'd4: f_data = (in_x & in_y) ^ (~in_x & in_z);
      3'd5: f_data = (in_x & in_y) ^ (in_x & in_z) ^ (in_y & in_z);
`endif
      default: begin
        f_data = '0;
        f_err  = 1'b1;
      end
    endcase
  end

`ifndef SHA_SIGMA_CHMAJ_EN
  logic unused_yz;
  assign unused_yz = ^{in_y, in_z};
`endif

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] err_q;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] ld;

  // Ready ripples from the output back to stage 0 in the same cycle.
  always_comb begin : flow
    logic nxt;
    nxt = out_ready;
    adv = '0;
    ld  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = valid_q[k] && nxt;
      ld[k]  = !valid_q[k] || adv[k];
      nxt    = ld[k];
    end
  end

  assign in_ready = !rst && ld[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      if (ld[0]) valid_q[0] <= in_valid;
      if (ld[0] && in_valid) begin
        data_q[0] <= f_data;
        tag_q[0]  <= in_tag;
        err_q[0]  <= f_err;
      end
      // Payload only moves with a word, so a drained stage keeps its last contents.
      for (int k = 1; k < STAGES; k++) begin
        if (ld[k]) valid_q[k] <= valid_q[k-1];
        if (adv[k-1]) begin
          data_q[k] <= data_q[k-1];
          tag_q[k]  <= tag_q[k-1];
          err_q[k]  <= err_q[k-1];
        end
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign out_err   = err_q[STAGES-1];

endmodule

// File: tb/tb_sha_sigma_pipe.sv
// Directed bench: 32-bit/2-stage and 64-bit/3-stage engines checked against a queued scoreboard.
module tb_sha_sigma_pipe;

  typedef struct {
    logic [63:0] d;
    logic [3:0]  t;
    logic        e;
    int          cyc;
    bit          lat;
  } entry_t;

  logic        clk;
  logic        a_rst, a_vld, a_irdy, a_ovld, a_ordy, a_oerr;
  logic [2:0]  a_mode;
  logic [31:0] a_x, a_y, a_z, a_odat;
  logic [3:0]  a_tag, a_otag;

  logic        b_rst, b_vld, b_irdy, b_ovld, b_ordy, b_oerr;
  logic [2:0]  b_mode;
  logic [63:0] b_x, b_y, b_z, b_odat;
  logic [3:0]  b_tag, b_otag;

  entry_t qa[$];
  entry_t qb[$];
  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int cyc    = 0;
  int b_emit = 0;

  sha_sigma_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4)) u_a (
    .clk(clk), .rst(a_rst), .in_valid(a_vld), .in_ready(a_irdy), .in_mode(a_mode),
    .in_x(a_x), .in_y(a_y), .in_z(a_z), .in_tag(a_tag), .out_valid(a_ovld),
    .out_ready(a_ordy), .out_data(a_odat), .out_tag(a_otag), .out_err(a_oerr)
  );

  sha_sigma_pipe #(.WIDTH(64), .STAGES(3), .TAG_W(4)) u_b (
    .clk(clk), .rst(b_rst), .in_valid(b_vld), .in_ready(b_irdy), .in_mode(b_mode),
    .in_x(b_x), .in_y(b_y), .in_z(b_z), .in_tag(b_tag), .out_valid(b_ovld),
    .out_ready(b_ordy), .out_data(b_odat), .out_tag(b_otag), .out_err(b_oerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%h expected=0x%h", nm, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon_a
    entry_t e;
    if (!a_rst && a_ovld && a_ordy) begin
      if (qa.size() == 0) chk("a_unexpected_output", 64'(a_odat), 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        e = qa.pop_front();
        chk("a_data", 64'(a_odat), e.d);
        chk("a_tag", 64'(a_otag), 64'(e.t));
        chk("a_err", 64'(a_oerr), 64'(e.e));
        if (e.lat) chk("a_latency", 64'(cyc - e.cyc), 64'd2);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    entry_t e;
    if (!b_rst && b_ovld && b_ordy) begin
      b_emit++;
      if (qb.size() == 0) chk("b_unexpected_output", b_odat, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        e = qb.pop_front();
        chk("b_data", b_odat, e.d);
        chk("b_tag", 64'(b_otag), 64'(e.t));
        chk("b_err", 64'(b_oerr), 64'(e.e));
        if (e.lat) chk("b_latency", 64'(cyc - e.cyc), 64'd3);
      end
    end
  end

  // Entered and left half a cycle... one step after a rising edge.
  task automatic send_a(input logic [2:0] m, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] z, input logic [3:0] t, input logic [31:0] ed,
                        input logic ee, input bit lat);
    entry_t e;
    bit ok;
    ok = 0;
    a_vld = 1'b1; a_mode = m; a_x = x; a_y = y; a_z = z; a_tag = t;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (a_irdy) begin
        e.d = 64'(ed); e.t = t; e.e = ee; e.cyc = cyc; e.lat = lat;
        qa.push_back(e);
        ok = 1;
      end
      @(posedge clk); #1;
    end
    a_vld = 1'b0;
    if (!ok) chk("a_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_b(input logic [2:0] m, input logic [63:0] x, input logic [3:0] t,
                        input logic [63:0] ed, input logic ee, input bit lat);
    entry_t e;
    bit ok;
    ok = 0;
    b_vld = 1'b1; b_mode = m; b_x = x; b_tag = t;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (b_irdy) begin
        e.d = ed; e.t = t; e.e = ee; e.cyc = cyc; e.lat = lat;
        qb.push_back(e);
        ok = 1;
      end
      @(posedge clk); #1;
    end
    b_vld = 1'b0;
    if (!ok) chk("b_accept_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  bp_mode [5];
    logic [63:0] bp_exp  [5];
    logic        bp_err  [5];
    int acc;
    int emit0;
    entry_t e;

    a_rst = 1'b1; a_vld = 1'b0; a_ordy = 1'b1; a_mode = '0; a_x = '0; a_y = '0; a_z = '0; a_tag = '0;
    b_rst = 1'b1; b_vld = 1'b0; b_ordy = 1'b1; b_mode = '0; b_x = '0; b_y = '0; b_z = '0; b_tag = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("a_in_ready_during_rst", 64'(a_irdy), 64'd0);
    chk("b_in_ready_during_rst", 64'(b_irdy), 64'd0);
    @(posedge clk); #1;
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    chk("a_rst_out_valid", 64'(a_ovld), 64'd0);
    chk("a_rst_in_ready", 64'(a_irdy), 64'd1);
    chk("a_rst_out_data", 64'(a_odat), 64'd0);
    chk("a_rst_out_tag", 64'(a_otag), 64'd0);
    chk("a_rst_out_err", 64'(a_oerr), 64'd0);
    chk("b_rst_out_valid", 64'(b_ovld), 64'd0);
    chk("b_rst_in_ready", 64'(b_irdy), 64'd1);
    chk("b_rst_out_data", b_odat, 64'd0);
    @(posedge clk); #1;

    // 32-bit: four sigma functions back to back, then high-bit operand exercising the shifts.
    send_a(3'd0, 32'h1, 32'h0, 32'h0, 4'd1, 32'h02004000, 1'b0, 1'b1);
    send_a(3'd1, 32'h1, 32'h0, 32'h0, 4'd2, 32'h0000A000, 1'b0, 1'b1);
    send_a(3'd2, 32'h1, 32'h0, 32'h0, 4'd3, 32'h40080400, 1'b0, 1'b1);
    send_a(3'd3, 32'h1, 32'h0, 32'h0, 4'd4, 32'h04200080, 1'b0, 1'b1);
    send_a(3'd0, 32'h80000000, 32'h0, 32'h0, 4'd5, 32'h11002000, 1'b0, 1'b1);
    send_a(3'd1, 32'h80000000, 32'h0, 32'h0, 4'd6, 32'h00205000, 1'b0, 1'b1);
    send_a(3'd2, 32'h80000000, 32'h0, 32'h0, 4'd7, 32'h20040200, 1'b0, 1'b1);
    send_a(3'd3, 32'h80000000, 32'h0, 32'h0, 4'd8, 32'h02100040, 1'b0, 1'b1);
`ifdef SHA_SIGMA_CHMAJ_EN
    send_a(3'd4, 32'hFFFF0000, 32'h12345678, 32'h9ABCDEF0, 4'd9, 32'h1234DEF0, 1'b0, 1'b1);
    send_a(3'd5, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0F0F0F0F, 4'd10, 32'hFF00FF00, 1'b0, 1'b1);
`else
    send_a(3'd4, 32'hFFFF0000, 32'h12345678, 32'h9ABCDEF0, 4'd9, 32'h0, 1'b1, 1'b1);
    send_a(3'd5, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0F0F0F0F, 4'd10, 32'h0, 1'b1, 1'b1);
`endif
    send_a(3'd6, 32'h1, 32'h0, 32'h0, 4'd11, 32'h0, 1'b1, 1'b1);
    send_a(3'd7, 32'hDEADBEEF, 32'h0, 32'h0, 4'd12, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 20 && qa.size() != 0; i++) @(posedge clk);
    chk("a_drain", 64'(qa.size()), 64'd0);
    @(posedge clk); #1;

    // 64-bit constants.
    send_b(3'd0, 64'h1, 4'd1, 64'h8100000000000000, 1'b0, 1'b1);
    send_b(3'd1, 64'h1, 4'd2, 64'h0000200000000008, 1'b0, 1'b1);
    send_b(3'd0, 64'h8000000000000000, 4'd3, 64'h4180000000000000, 1'b0, 1'b1);
    send_b(3'd1, 64'h8000000000000000, 4'd4, 64'h0200100000000004, 1'b0, 1'b1);
    send_b(3'd7, 64'hDEADBEEF, 4'd5, 64'h0, 1'b1, 1'b1);
    for (int i = 0; i < 20 && qb.size() != 0; i++) @(posedge clk);
    chk("b_drain", 64'(qb.size()), 64'd0);
    @(posedge clk); #1;

    // Backpressure: 3-deep pipe, five words offered with the consumer stalled.
    bp_mode[0] = 3'd2; bp_exp[0] = 64'h0000001042000000; bp_err[0] = 1'b0;
    bp_mode[1] = 3'd3; bp_exp[1] = 64'h0004400000800000; bp_err[1] = 1'b0;
    bp_mode[2] = 3'd0; bp_exp[2] = 64'h8100000000000000; bp_err[2] = 1'b0;
    bp_mode[3] = 3'd1; bp_exp[3] = 64'h0000200000000008; bp_err[3] = 1'b0;
    bp_mode[4] = 3'd7; bp_exp[4] = 64'h0;                bp_err[4] = 1'b1;
    b_ordy = 1'b0;
    acc = 0;
    b_vld = 1'b1; b_mode = bp_mode[0]; b_x = 64'h1; b_tag = 4'd8;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (b_irdy && acc < 5) begin
        e.d = bp_exp[acc]; e.t = 4'(8 + acc); e.e = bp_err[acc]; e.cyc = cyc; e.lat = 1'b0;
        qb.push_back(e);
        acc++;
      end
      @(posedge clk); #1;
      if (acc < 5) begin
        b_mode = bp_mode[acc]; b_tag = 4'(8 + acc);
      end
    end
    @(negedge clk);
    chk("bp_accepted", 64'(acc), 64'd3);
    chk("bp_in_ready_full", 64'(b_irdy), 64'd0);
    chk("bp_out_valid_held", 64'(b_ovld), 64'd1);
    chk("bp_out_data_held", b_odat, bp_exp[0]);
    @(posedge clk); #1;
    b_vld = 1'b0;
    emit0 = b_emit;
    b_ordy = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    chk("bp_emitted_per_cycle", 64'(b_emit - emit0), 64'd3);
    chk("bp_empty_after", 64'(b_ovld), 64'd0);
    chk("bp_queue_empty", 64'(qb.size()), 64'd0);

    // Reset with two words in flight.
    b_ordy = 1'b0;
    send_b(3'd0, 64'h1, 4'd6, 64'h8100000000000000, 1'b0, 1'b0);
    send_b(3'd1, 64'h1, 4'd7, 64'h0000200000000008, 1'b0, 1'b0);
    b_rst = 1'b1;
    qb.delete();
    @(negedge clk);
    chk("flush_in_ready_in_rst", 64'(b_irdy), 64'd0);
    @(posedge clk); #1;
    b_rst = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(b_ovld), 64'd0);
    chk("flush_in_ready", 64'(b_irdy), 64'd1);
    @(posedge clk); #1;
    emit0 = b_emit;
    b_ordy = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("flush_no_output", 64'(b_emit - emit0), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
